// File: rtl/mult_seq.sv
//------------------------------------------------------------------------------
// mult_seq -- iterative shift-add multiplier with valid/ready handshakes.
//
// One partial product is folded into the accumulator per clock. An operation
// takes W BUSY cycles, then the result sits in DONE until the consumer takes
// it. A new operand pair is accepted only in IDLE. There is no input queue.
//
// Optional feature macro: MULT_SEQ_SIGNED_EN
//   Defined   : adds the per-operation `tc` port. With tc=1 the operands are
//               two's complement. The multiplicand is sign-extended, the last
//               step subtracts, and the accumulator shifts arithmetically.
//   Undefined : unsigned only. There is no tc port and no subtract path.
//
// Parameters
//   W          operand width (W >= 2). The product is 2*W bits.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   A/B (and tc) are valid
//   in_ready   high only in IDLE; decoded from the state register alone
//   A, B       multiplicand, multiplier
//   tc         two's-complement mode (only with MULT_SEQ_SIGNED_EN)
//   out_valid  Product is valid (registered)
//   out_ready  consumer accepts Product
//   Product    registered 2*W-bit result; keeps its value after hand-off
//------------------------------------------------------------------------------
module mult_seq #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic             tc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   Product
);

  // The counter must be able to hold W after the final increment.
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W:0]         mcand_q, mcand_d;
  logic [W:0]         hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*W-1:0]     product_q, product_d;
  logic               out_valid_q, out_valid_d;
`ifdef MULT_SEQ_SIGNED_EN
  logic               tc_q, tc_d;
`endif

  logic               accept_s;
  logic               last_step_s;
  logic               sub_s;
  logic               shift_fill_s;
  logic [W:0]         step_sum_s;
  logic [W:0]         step_hi_s;
  logic [W-1:0]       step_lo_s;
  logic [W:0]         mcand_load_s;

  //----------------------------------------------------------------------------
  // FSM
  //----------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (last_step_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. in_ready depends on the state register only.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_BUSY:  in_ready = 1'b0;
      S_DONE:  in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  //----------------------------------------------------------------------------
  // Datapath
  //----------------------------------------------------------------------------

  // Handshake and step qualifiers.
  always_comb begin
    accept_s    = (state_q == S_IDLE) && in_valid;
    last_step_s = (state_q == S_BUSY) && (cnt_q == CNT_LAST);
  end

  // Mode-dependent controls. In signed mode the multiplier's sign bit has
  // negative weight, so its partial product is subtracted. The shift must
  // also preserve the accumulator's sign.
  always_comb begin
`ifdef MULT_SEQ_SIGNED_EN
    if (tc) begin
      mcand_load_s = {A[W-1], A};
    end else begin
      mcand_load_s = {1'b0, A};
    end
    sub_s        = tc_q & (cnt_q == CNT_LAST);
    shift_fill_s = tc_q & step_sum_s[W];
`else
    mcand_load_s = {1'b0, A};
    sub_s        = 1'b0;
    shift_fill_s = 1'b0;
`endif
  end

  // One shift-add step. hi is W+1 bits, so the add/subtract result fits
  // before the right shift.
  always_comb begin
    step_sum_s = hi_q;
    if (lo_q[0]) begin
`ifdef MULT_SEQ_SIGNED_EN
      if (sub_s) begin
        step_sum_s = hi_q - mcand_q;
      end else begin
        step_sum_s = hi_q + mcand_q;
      end
`else
      step_sum_s = hi_q + mcand_q;
`endif
    end else begin
      step_sum_s = hi_q;
    end
    step_hi_s = {shift_fill_s, step_sum_s[W:1]};
    step_lo_s = {step_sum_s[0], lo_q[W-1:1]};
  end

  // Next values for the datapath registers.
  always_comb begin
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
`ifdef MULT_SEQ_SIGNED_EN
    tc_d        = tc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          mcand_d = mcand_load_s;
          hi_d    = {(W+1){1'b0}};
          lo_d    = B;
          cnt_d   = {CW{1'b0}};
`ifdef MULT_SEQ_SIGNED_EN
          tc_d    = tc;
`endif
        end else begin
          mcand_d = mcand_q;
        end
      end
      S_BUSY: begin
        hi_d  = step_hi_s;
        lo_d  = step_lo_s;
        cnt_d = cnt_q + CNT_ONE;
        // The result is captured on the same edge as the last step.
        if (last_step_s) begin
          product_d   = {step_hi_s[W-1:0], step_lo_s};
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      S_DONE: begin
        // Product is held, and not cleared, after the hand-off.
        if (out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q     <= {(W+1){1'b0}};
      hi_q        <= {(W+1){1'b0}};
      lo_q        <= {W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      product_q   <= {(2*W){1'b0}};
      out_valid_q <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      tc_q        <= 1'b0;
`endif
    end else begin
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
`ifdef MULT_SEQ_SIGNED_EN
      tc_q        <= tc_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign Product   = product_q;

endmodule
